alu_control_pipe: RTL and testbench

ALU_CONTROL_PIPE -- requirements
Module: alu_control_pipe

---
 rtl/alu_ctrl_pkg.sv | 64 ++++++
 rtl/alu_control_pipe.sv | 104 ++++++++++
 tb/tb_alu_control_pipe.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control pipeline: opcode/funct constants,
// 3-bit ALU control codes, FSM state encoding and the instruction decode table.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_MC_WAIT = 2'd2
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;

  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SUB = 3'b011;
  localparam logic [2:0] CTRL_XOR = 3'b100;
  localparam logic [2:0] CTRL_NOR = 3'b101;
  localparam logic [2:0] CTRL_SLL = 3'b110;
  localparam logic [2:0] CTRL_SRL = 3'b111;

  typedef struct packed {
    logic [2:0] ctrl;
    logic       mc;
    logic       illegal;
  } dec_t;

  // Anything not listed falls through to illegal with a zero control code.
  function automatic dec_t decode(input logic [5:0] opcode, input logic [5:0] funct);
    dec_t d;
    d = '{ctrl: CTRL_AND, mc: 1'b0, illegal: 1'b0};
    if (opcode == OP_RTYPE) begin
      case (funct)
        6'd0:    d.ctrl = CTRL_AND;
        6'd1:    d.ctrl = CTRL_ADD;
        6'd2:    d.ctrl = CTRL_SUB;
        6'd3:    d.ctrl = CTRL_AND;
        6'd4:    d.ctrl = CTRL_OR;
        6'd5:    d.ctrl = CTRL_NOR;
        6'd6:    d.ctrl = CTRL_SLL;
        6'd7:    d.ctrl = CTRL_SRL;
        FN_MULT: begin d.ctrl = CTRL_ADD; d.mc = 1'b1; end
        FN_DIV:  begin d.ctrl = CTRL_SUB; d.mc = 1'b1; end
        default: d.illegal = 1'b1;
      endcase
    end else begin
      case (opcode)
        6'd1:    d.ctrl = CTRL_ADD;
        6'd2:    d.ctrl = CTRL_SUB;
        6'd3:    d.ctrl = CTRL_AND;
        6'd4:    d.ctrl = CTRL_XOR;
        6'd5:    d.ctrl = CTRL_NOR;
        6'd6:    d.ctrl = CTRL_AND;
        6'd7:    d.ctrl = CTRL_AND;
        6'd8:    d.ctrl = CTRL_AND;
        default: d.illegal = 1'b1;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_control_pipe.sv
// ALU control decoder with a one-entry valid/ready output stage; mult/div
// results are withheld for MC_CYCLES cycles to model a multi-cycle unit.
module alu_control_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int INST_W    = 32,
  parameter int CTRL_W    = 3,
  parameter int MC_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              mc_op,
  output logic              illegal,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(MC_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit              MC_MULTI = (MC_CYCLES > 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic             mc_q, mc_d;
  logic             ill_q, ill_d;
  dec_t             dec;
  logic             accept;
  logic             unused_inst;

  // Only opcode and funct matter; the rest of the word is deliberately ignored.
  assign unused_inst = ^inst;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl_d   = ctrl_q;
    mc_d     = mc_q;
    ill_d    = ill_q;
    in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    dec      = decode(inst[31:26], inst[5:0]);
    accept   = in_valid && in_ready;

    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          ctrl_d = dec.ctrl;
          mc_d   = dec.mc;
          ill_d  = dec.illegal;
          if (dec.mc && MC_MULTI) begin
            state_d = ST_MC_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ST_HOLD;
          end
        end else if ((state_q == ST_HOLD) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_MC_WAIT: begin
        // Leaving at a count of one makes the result appear MC_CYCLES cycles after accept.
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      mc_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      mc_q    <= mc_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q == ST_MC_WAIT);
  assign ctrl_out  = CTRL_W'(ctrl_q);
  assign mc_op     = mc_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_control_pipe.sv
// Self-checking bench: directed latency/stall/reset scenarios plus a random
// handshake phase, all results checked through a scoreboard queue.
module tb_alu_control_pipe;

  localparam int INST_W    = 32;
  localparam int CTRL_W    = 3;
  localparam int MC_CYCLES = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] inst;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] ctrl_out;
  logic              mc_op;
  logic              illegal;
  logic              busy;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  alu_control_pipe #(
    .INST_W(INST_W), .CTRL_W(CTRL_W), .MC_CYCLES(MC_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_out(ctrl_out), .mc_op(mc_op), .illegal(illegal), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode as lookup tables; packs {ctrl, mc, illegal}.
  function automatic logic [4:0] ref_decode(input logic [31:0] w);
    logic [2:0] r_tab [0:7];
    logic [2:0] i_tab [1:8];
    logic [5:0] op, fn;
    r_tab = '{3'd0, 3'd2, 3'd3, 3'd0, 3'd1, 3'd5, 3'd6, 3'd7};
    i_tab = '{3'd2, 3'd3, 3'd0, 3'd4, 3'd5, 3'd0, 3'd0, 3'd0};
    op = w[31:26];
    fn = w[5:0];
    if (op == 6'd0) begin
      if (fn < 6'd8)        return {r_tab[fn[2:0]], 2'b00};
      else if (fn == 6'h18) return {3'd2, 2'b10};
      else if (fn == 6'h1A) return {3'd3, 2'b10};
      else                  return 5'b000_01;
    end else if (op >= 6'd1 && op <= 6'd8) begin
      return {i_tab[int'(op)], 2'b00};
    end
    return 5'b000_01;
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
    return {op, 20'($urandom), fn};
  endfunction

  // Scoreboard: push on input handshake, pop/compare on output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          check_eq("sb_result", {27'd0, ctrl_out, mc_op, illegal}, {27'd0, e});
          $display("out: ctrl=%b mc=%b ill=%b exp=%b", ctrl_out, mc_op, illegal, e);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_decode(inst));
        $display("in : inst=%h", inst);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    inst      = '0;
    out_ready = 1'b1;
    repeat (3) step();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_ctrl", 32'(ctrl_out), 32'd0);
    check_eq("rst_mc_ill_busy", {29'd0, mc_op, illegal, busy}, 32'd0);
    rst_n = 1'b1;
    step();
    check_eq("rel_in_ready", 32'(in_ready), 32'd1);

    // Single-cycle R-type, latency 1
    in_valid = 1'b1; inst = mk(6'd0, 6'd5);
    step();
    in_valid = 1'b0;
    check_eq("rt5_valid", 32'(out_valid), 32'd1);
    check_eq("rt5_ctrl", 32'(ctrl_out), 32'd5);
    check_eq("rt5_mc_ill", {30'd0, mc_op, illegal}, 32'd0);
    step();

    // Back-to-back opcode 4 then opcode 2
    in_valid = 1'b1; inst = mk(6'd4, 6'($urandom));
    step();
    check_eq("b2b_ctrl0", 32'(ctrl_out), 32'd4);
    check_eq("b2b_ready", 32'(in_ready), 32'd1);
    inst = mk(6'd2, 6'($urandom));
    step();
    in_valid = 1'b0;
    check_eq("b2b_ctrl1", 32'(ctrl_out), 32'd3);
    check_eq("b2b_valid1", 32'(out_valid), 32'd1);
    step();

    // Multi-cycle mult
    in_valid = 1'b1; inst = mk(6'd0, 6'h18);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < MC_CYCLES - 1; i++) begin
      check_eq("mc_wait_flags", {29'd0, busy, in_ready, out_valid}, 32'b100);
      step();
    end
    check_eq("mc_valid", 32'(out_valid), 32'd1);
    check_eq("mc_ctrl", 32'(ctrl_out), 32'd2);
    check_eq("mc_flag", 32'(mc_op), 32'd1);
    step();

    // Illegal opcode held under back-pressure; offered input must be ignored
    out_ready = 1'b0;
    in_valid = 1'b1; inst = mk(6'h3F, 6'd1);
    step();
    inst = mk(6'd5, 6'd0);
    check_eq("ill_flag", 32'(illegal), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("ill_hold", {25'd0, out_valid, in_ready, ctrl_out, mc_op, illegal}, 32'b10_000_01);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();

    // Reset during MC_WAIT of div discards the op
    in_valid = 1'b1; inst = mk(6'd0, 6'h1A);
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("rstmc_flags", {29'd0, out_valid, in_ready, busy}, 32'b010);
    for (int i = 0; i < MC_CYCLES + 2; i++) begin
      step();
      check_eq("rstmc_no_out", 32'(out_valid), 32'd0);
    end

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op, fn;
      int sel;
      sel = $urandom_range(0, 11);
      op  = (sel == 11) ? 6'h3F : (sel == 10) ? 6'($urandom) : 6'(sel);
      sel = $urandom_range(0, 11);
      fn  = (sel < 8) ? 6'(sel) : (sel == 8) ? 6'h18 : (sel == 9) ? 6'h1A : 6'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      inst      = mk(op, fn);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4 * MC_CYCLES + 10 && exp_q.size() != 0; i++) step();
    step();
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
